// File: rtl/sigma_pkg.sv
// Shared types for the sigma DPE issue path.
//  issue_state_e : issue FSM states (IDLE, ACTIVE, DRAIN)
//  dpe_cmd_t     : one queued DPE command {data, stationary, dest, vn_sep}
//  CMD_W         : packed width of dpe_cmd_t, used to size the command FIFO
package sigma_pkg;

  localparam int IN_DATA_TYPE = 16;
  localparam int NUM_PES      = 32;
  localparam int LOG2_PES     = 5;
  localparam int DATA_BUS_W   = NUM_PES * IN_DATA_TYPE;
  localparam int IDX_BUS_W    = NUM_PES * LOG2_PES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [DATA_BUS_W-1:0] data;
    logic                  stationary;
    logic [IDX_BUS_W-1:0]  dest;
    logic [IDX_BUS_W-1:0]  vn_sep;
  } dpe_cmd_t;

  localparam int CMD_W = $bits(dpe_cmd_t);

endpackage

// File: rtl/sigma_sync_fifo.sv
// Synchronous FIFO with occupancy count and combinational head read.
//  clk, rst (sync, active-low)
//  push, wr_data : write one entry (caller guarantees not full)
//  pop           : drop the head entry (caller guarantees not empty)
//  rd_data       : current head entry
//  count         : entries held, 0..DEPTH
module sigma_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic [LOG2_DEPTH:0]   count
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sigma_dpe_issue_queue.sv
// Buffered command issuer in front of flexdpe.
//  clk, rst (sync, active-low)
//  i_valid/o_ready + i_data_bus, i_stationary, i_dest_bus, i_vn_seperator : command input
//  i_enable        : 0 pauses issue (pushes still accepted)
//  o_data_valid, o_data_bus, o_stationary, o_dest_bus, o_vn_seperator     : registered DPE command
//  o_fifo_count    : entries queued
//  o_issue_count   : streaming vectors issued (wraps)
//  o_busy          : FSM not idle or queue non-empty
// A stationary load is held back until DRAIN_CYCLES idle cycles have passed
// since the last streaming issue, so weights never overtake streaming data
// still in the reduction network.
module sigma_dpe_issue_queue
  import sigma_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int LOG2_DEPTH   = 3,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_BUS_W-1:0] i_data_bus,
  input  logic                  i_stationary,
  input  logic [IDX_BUS_W-1:0]  i_dest_bus,
  input  logic [IDX_BUS_W-1:0]  i_vn_seperator,
  input  logic                  i_enable,
  output logic                  o_data_valid,
  output logic [DATA_BUS_W-1:0] o_data_bus,
  output logic                  o_stationary,
  output logic [IDX_BUS_W-1:0]  o_dest_bus,
  output logic [IDX_BUS_W-1:0]  o_vn_seperator,
  output logic [LOG2_DEPTH:0]   o_fifo_count,
  output logic [15:0]           o_issue_count,
  output logic                  o_busy
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [LOG2_DEPTH:0] DEPTH_L    = (LOG2_DEPTH + 1)'(FIFO_DEPTH);

  dpe_cmd_t            wr_cmd;
  dpe_cmd_t            head;
  logic [LOG2_DEPTH:0] fifo_count;
  logic                push;
  logic                head_vld;
  logic                issue;
  issue_state_e        state;
  issue_state_e        state_next;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [15:0]         issue_cnt;
  dpe_cmd_t            cmd_p1;
  logic                vld_p1;

  assign o_ready  = (fifo_count < DEPTH_L);
  assign push     = i_valid & o_ready;
  assign head_vld = (fifo_count != '0);
  assign wr_cmd   = {i_data_bus, i_stationary, i_dest_bus, i_vn_seperator};

  sigma_sync_fifo #(
    .WIDTH      (CMD_W),
    .DEPTH      (FIFO_DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (issue),
    .rd_data (head),
    .count   (fifo_count)
  );

  // Stage p0: issue decision on the FIFO head
  always_comb begin
    issue      = 1'b0;
    state_next = state;
    if (i_enable) begin
      case (state)
        IDLE: begin
          if (head_vld) begin
            issue      = 1'b1;
            state_next = ACTIVE;
          end
        end
        ACTIVE: begin
          if (head_vld) begin
            if (!head.stationary || drain_cnt == '0) issue = 1'b1;
            else                                     state_next = DRAIN;
          end else if (drain_cnt == '0) begin
            state_next = IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            issue      = 1'b1;
            state_next = ACTIVE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_next;
      // Counts down even while paused so a pause shortens the wait.
      if (issue && !head.stationary) drain_cnt <= DRAIN_LOAD;
      else if (drain_cnt != '0)      drain_cnt <= drain_cnt - 1'b1;
      if (issue && !head.stationary) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Stage p1: popped command register
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    cmd_p1 <= head;
  end

  // Stage p2: DPE output register, zeroed on non-issue cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_data_valid   <= 1'b0;
      o_data_bus     <= '0;
      o_stationary   <= 1'b0;
      o_dest_bus     <= '0;
      o_vn_seperator <= '0;
    end else begin
      o_data_valid   <= vld_p1;
      o_data_bus     <= vld_p1 ? cmd_p1.data       : '0;
      o_stationary   <= vld_p1 ? cmd_p1.stationary : 1'b0;
      o_dest_bus     <= vld_p1 ? cmd_p1.dest       : '0;
      o_vn_seperator <= vld_p1 ? cmd_p1.vn_sep     : '0;
    end
  end

  assign o_fifo_count  = fifo_count;
  assign o_issue_count = issue_cnt;
  assign o_busy        = (state != IDLE) || head_vld;

endmodule
